// File: rtl/rtc_bus_master_burst_if.sv
// Processor command port and RTC strobe pins of rtc_bus_master_burst.
// The multiplexed dato bus stays a plain inout port on the master itself.
interface rtc_bus_master_burst_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              start;
    logic              rw;
    logic [DATA_W-1:0] addr;
    logic [LEN_W-1:0]  burst_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              reg_a_d;
    logic              reg_cs;
    logic              reg_rd;
    logic              reg_wr;

    modport master (
        input  start, rw, addr, burst_len, wr_data,
        output wr_ack, rd_data, rd_valid, busy, done,
        output reg_a_d, reg_cs, reg_rd, reg_wr
    );

    modport slave (
        output start, rw, addr, burst_len, wr_data,
        input  wr_ack, rd_data, rd_valid, busy, done,
        input  reg_a_d, reg_cs, reg_rd, reg_wr
    );
endinterface

// File: rtl/rtc_bus_master_burst.sv
// Burst master for a multiplexed address/data RTC bus with programmable phase timing.
// Define RTC_ADDR_AUTOINC_EN to step the address on every beat; otherwise each beat reuses it.
module rtc_bus_master_burst #(
    parameter int DATA_W  = 8,
    parameter int T_SETUP = 1,
    parameter int T_PULSE = 2,
    parameter int T_HOLD  = 1,
    parameter int T_GAP   = 1,
    parameter int LEN_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    rtc_bus_master_burst_if.master bus,
    inout  wire  [DATA_W-1:0]      dato
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SETUP,
        S_A_PULSE,
        S_A_HOLD,
        S_D_SETUP,
        S_D_PULSE,
        S_D_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    localparam int T_MAX_SP  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX_HG  = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int T_MAX     = (T_MAX_SP > T_MAX_HG) ? T_MAX_SP : T_MAX_HG;
    localparam int CNT_W     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_load;
    logic              r_rw;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic [LEN_W-1:0]  r_beats;
    logic              r_wr_ack;
    logic              r_rd_valid;

    logic              w_tdone;
    logic              w_more;
    logic              w_oe;
    logic [DATA_W-1:0] w_dout;
    logic              w_a_d;
    logic              w_cs;
    logic              w_rd;
    logic              w_wr;

    assign w_tdone = (r_cnt == '0);
    assign w_more  = (r_beats > LEN_W'(1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_A_SETUP;
            S_A_SETUP: if (w_tdone)   w_next = S_A_PULSE;
            S_A_PULSE: if (w_tdone)   w_next = S_A_HOLD;
            S_A_HOLD:  if (w_tdone)   w_next = S_D_SETUP;
            S_D_SETUP: if (w_tdone)   w_next = S_D_PULSE;
            S_D_PULSE: if (w_tdone)   w_next = S_D_HOLD;
            S_D_HOLD:  if (w_tdone)   w_next = w_more ? S_GAP : S_DONE;
            S_GAP:     if (w_tdone)   w_next = S_A_SETUP;
            S_DONE:                   w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    // Every timed state reloads the shared down-counter with its length minus one on entry.
    always_comb begin
        w_cnt_load = '0;
        case (w_next)
            S_A_SETUP, S_D_SETUP: w_cnt_load = CNT_W'(T_SETUP - 1);
            S_A_PULSE, S_D_PULSE: w_cnt_load = CNT_W'(T_PULSE - 1);
            S_A_HOLD,  S_D_HOLD:  w_cnt_load = CNT_W'(T_HOLD - 1);
            S_GAP:                w_cnt_load = CNT_W'(T_GAP - 1);
            default:              w_cnt_load = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_beats    <= '0;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;

            if (w_next != r_state) begin
                r_cnt <= w_cnt_load;
            end else if (!w_tdone) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (r_state == S_IDLE && bus.start) begin
                r_rw    <= bus.rw;
                r_addr  <= bus.addr;
                r_beats <= (bus.burst_len == '0) ? LEN_W'(1) : bus.burst_len;
            end

            if (r_state == S_A_HOLD && w_next == S_D_SETUP && !r_rw) begin
                r_wdata  <= bus.wr_data;
                r_wr_ack <= 1'b1;
            end

            // The RTC still drives the bus on the last strobe-low cycle, so sample it here.
            if (r_state == S_D_PULSE && w_next == S_D_HOLD && r_rw) begin
                r_rd_data  <= dato;
                r_rd_valid <= 1'b1;
            end

            if (r_state == S_D_HOLD && w_next == S_GAP) begin
                r_beats <= r_beats - LEN_W'(1);
`ifdef RTC_ADDR_AUTOINC_EN
                r_addr  <= r_addr + DATA_W'(1);
`endif
            end
        end
    end

    always_comb begin
        w_a_d  = 1'b0;
        w_cs   = 1'b1;
        w_rd   = 1'b1;
        w_wr   = 1'b1;
        w_oe   = 1'b0;
        w_dout = r_addr;
        case (r_state)
            S_A_SETUP, S_A_HOLD: begin
                w_cs = 1'b0;
                w_oe = 1'b1;
            end
            S_A_PULSE: begin
                w_cs = 1'b0;
                w_oe = 1'b1;
                w_wr = 1'b0;
            end
            S_D_SETUP, S_D_HOLD: begin
                w_a_d  = 1'b1;
                w_cs   = 1'b0;
                w_oe   = !r_rw;
                w_dout = r_wdata;
            end
            S_D_PULSE: begin
                w_a_d  = 1'b1;
                w_cs   = 1'b0;
                w_oe   = !r_rw;
                w_dout = r_wdata;
                w_wr   = r_rw;
                w_rd   = !r_rw;
            end
            default: begin
                w_cs = 1'b1;
            end
        endcase
    end

    assign dato         = w_oe ? w_dout : {DATA_W{1'bz}};
    assign bus.reg_a_d  = w_a_d;
    assign bus.reg_cs   = w_cs;
    assign bus.reg_rd   = w_rd;
    assign bus.reg_wr   = w_wr;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.wr_ack   = r_wr_ack;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;

endmodule

// File: doc/rtc_bus_master_burst.md
Name: rtc_bus_master_burst

Overview:
Parametrised master for a multiplexed address/data RTC parallel bus with active-low chip select, read strobe and write strobe, and an a_d select. Each beat is an address phase followed by a data phase. Phase timing is set per parameter, and one command can run a multi-register burst. It sits between the processor port decode logic and the RTC pins, and replaces the fixed-timing single-access controller plus bus driver pair.

Parameters:
DATA_W, 8, width of the address/data bus and of the address/data registers
T_SETUP, 1, cycles signals are stable before a strobe falls (min 1)
T_PULSE, 2, cycles the strobe is held low (min 1)
T_HOLD, 1, cycles signals are held after the strobe rises (min 1)
T_GAP, 1, cycles cs is high between burst beats (min 1)
LEN_W, 4, width of burst_len

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
rw  in  1  1 = read, 0 = write; sampled with start
addr  in  DATA_W  first RTC register address; sampled with start
burst_len  in  LEN_W  number of beats; 0 is treated as 1; sampled with start
wr_data  in  DATA_W  write data for the current beat
wr_ack  out  1  one-cycle pulse when wr_data has been captured
rd_data  out  DATA_W  last captured read byte
rd_valid  out  1  one-cycle pulse when rd_data is updated
busy  out  1  high from ADDR_SETUP through DONE
done  out  1  one-cycle pulse in DONE
reg_a_d  out  1  0 = address phase, 1 = data phase
reg_cs  out  1  chip select, active low
reg_rd  out  1  read strobe, active low
reg_wr  out  1  write strobe, active low
dato  inout  DATA_W  RTC multiplexed bus

Behaviour:
- Reset values, applied on the next clk edge, also mid-burst: state IDLE; reg_cs, reg_rd, reg_wr = 1; reg_a_d = 0; dato = high-Z; busy, done, wr_ack, rd_valid = 0; rd_data = 0; counters = 0.
- States: IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, GAP, DONE.
  - Each timed state lasts its parameter count, using a shared down-counter.
- IDLE:
  - start=1 → latch rw, addr, beat count (max(burst_len,1)) → A_SETUP.
  - start in any other state is ignored.
- Address phase (A_*):
  - reg_a_d = 0, reg_cs = 0, dato driven with the current address.
  - reg_wr = 0 during A_PULSE only; reg_rd stays 1.
- Data phase (D_*):
  - reg_a_d = 1, reg_cs = 0.
  - Write:
    - wr_data is captured on entry to D_SETUP, with wr_ack pulsed that cycle.
    - dato is driven with the captured value; reg_wr = 0 during D_PULSE.
  - Read:
    - dato is high-Z for all D_* states; reg_rd = 0 during D_PULSE.
    - dato is sampled on the last D_PULSE cycle into rd_data.
    - rd_valid pulses the next cycle.
- After D_HOLD:
  - If beats remain → GAP (reg_cs = 1, dato high-Z, reg_a_d = 0) → A_SETUP with the next address.
  - Otherwise → DONE (reg_cs = 1) → IDLE.
- Strobes are never low in the same cycle as a change of reg_a_d or of the driven dato value.
- Cycles per beat: 2*(T_SETUP+T_PULSE+T_HOLD). Each gap adds T_GAP, and DONE adds 1.
  - Defaults, single beat: start sampled at edge k; done is high in the 9th cycle after k.
- Address arithmetic: modulo 2^DATA_W, so 0xFF wraps to 0x00 for DATA_W=8.
- reset has priority over start in the same cycle.

Optional Feature:
Macro RTC_ADDR_AUTOINC_EN.
- Defined: the address increments by 1 (with wrap) for each burst beat.
- Undefined: every beat reuses the latched address, giving repeated access to one register (polling). Beat count and all timing are unchanged.

Test Plan:
- Defaults, write addr=0x21, wr_data=0x45, burst_len=1:
  - A_PULSE: reg_wr low 2 cycles with dato=0x21, reg_a_d=0.
  - D_PULSE: reg_wr low 2 cycles with dato=0x45, reg_a_d=1.
  - One wr_ack pulse; done 9 cycles after start.
- Read addr=0x24, RTC model returns 0x59 while reg_rd=0:
  - dato is high-Z during data phase.
  - rd_data=0x59 with one rd_valid pulse; done follows.
- Read burst, burst_len=3, addr=0xFE, autoinc on:
  - Address phases carry 0xFE, 0xFF, 0x00.
  - 3 rd_valid pulses; reg_cs high exactly T_GAP cycles between beats.
- Same burst with the macro undefined:
  - All three address phases carry 0xFE; 3 rd_valid pulses.
- reset asserted in D_PULSE of a write:
  - Next cycle: reg_cs=reg_wr=reg_rd=1, dato high-Z, busy=0, no done.
  - A new start afterwards completes normally.
- start pulsed while busy, and burst_len=0:
  - The second start is ignored.
  - burst_len=0 performs exactly one beat, then done.
